ext_pipe: RTL and testbench
===========================

Name: ext_pipe

Overview:
- Parametrised, registered immediate-extension stage for the pipelined CPU datapath. It sits between decode and the execute-stage operand mux.
- Extends an IMM_W-bit immediate to DATA_W bits under one of five modes, and carries a sideband tag (e.g. PC/instr id) alongside.
- Uses a valid/ready handshake with a 2-entry skid buffer, so downstream stalls never drop or duplicate an immediate.
- Flush discards all in-flight entries.

Parameters:
- IMM_W, 16, immediate input width (2 ≤ IMM_W ≤ DATA_W-2).
- DATA_W, 32, extended output width.
- TAG_W, 32, width of sideband tag passed through unchanged.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted, release synchronous to clk).
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream has an immediate.
- in_ready  out  1  stage can accept this cycle.
- imm  in  IMM_W  raw immediate.
- ext_op  in  3  extension mode.
- in_tag  in  TAG_W  sideband.
- out_valid  out  1  out_data/out_tag valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  extended value.
- out_tag  out  TAG_W  tag of out_data.
- occupancy  out  2  entries held (0..2).

Behaviour:
- ext_op encoding:
  - 0 SIGN: sign-extend imm.
  - 1 ZERO: zero-extend imm.
  - 2 UPPER: imm placed at [DATA_W-1 : DATA_W-IMM_W], low bits 0.
  - 3 BRANCH: sign-extend, then shift left 2 (top bits dropped).
  - 4 ZERO_SHL2: zero-extend, then shift left 2.
  - 5..7: result 0.
- Extension is computed combinationally at input. Only the result is stored, never the raw imm.
- Reset values: out_valid=0, out_data=0, out_tag=0, occupancy=0, skid empty. in_ready=1 while reset deasserted and stage empty. in_ready=0 while reset asserted.
- Storage: main register M (drives outputs) plus skid register S. Registers only; no combinational path from out_ready to in_ready.
- in_ready = !S.valid (registered).
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Latency: accepted item appears on out_* the next cycle if M was empty or is draining that cycle. Throughput 1 item/cycle with out_ready=1.
- Per-cycle update (flush not asserted):
  - M empty or out transfer, S empty: M ← input if in transfer, else M.valid ← 0.
  - M empty or out transfer, S full: M ← S, and S ← input if in transfer, else S.valid ← 0.
  - M full and out_ready=0: on in transfer, S ← input (S was empty, guaranteed by in_ready).
- Ordering is strictly FIFO; M always holds the older entry.
- flush=1: M.valid and S.valid cleared next edge. Any simultaneous in transfer is discarded, as is any simultaneous out transfer by this stage. Data registers may keep stale values.
- occupancy = M.valid + S.valid. It never reaches 2 while in_ready=1 in the following cycle.
- Reset mid-operation: all entries lost immediately (asynchronous). Outputs return to reset values without waiting for clk.
- in_valid with in_ready=0: input ignored. Upstream must hold it (not checked here).

Decomposition:
- Shared package ext_pkg holds:
  - localparams EXT_SIGN=0, EXT_ZERO=1, EXT_UPPER=2, EXT_BRANCH=3, EXT_ZSHL2=4;
  - EXT_OP_W=3.
  Decoder/controller uses the same constants.
- One sub-module, ext_core: purely combinational (imm, ext_op) → DATA_W result, parametrised by IMM_W/DATA_W.
- ext_pipe holds only the handshake/skid logic.

Test Plan:
- Modes with out_ready=1, DATA_W=32, IMM_W=16, one item each, next cycle out_data:
  - SIGN 0x8000 → 0xFFFF8000.
  - ZERO 0x8000 → 0x00008000.
  - UPPER 0x1234 → 0x12340000.
  - BRANCH 0xFFFF → 0xFFFFFFFC.
  - ZSHL2 0xFFFF → 0x0003FFFC.
  - op 7 → 0.
- Backpressure: out_ready=0, push tags 1,2,3 back-to-back.
  - Tags 1,2 accepted; in_ready=0 after second; occupancy=2.
  - Raise out_ready: outputs tag 1, then 2, then 3 (after re-accept); no loss or duplication.
- Streaming: 100 random items, out_ready=1 constantly. One output per cycle, 1-cycle latency, occupancy ≤1.
- Flush: occupancy=2, assert flush with in_valid=1. Next cycle out_valid=0, occupancy=0, in_ready=1; flushed item never appears.
- Async reset: drop reset between clock edges with occupancy=2. out_valid=0, occupancy=0 immediately. After release, first accepted item outputs correctly.
- Random out_ready toggling vs scoreboard over 1000 items: output sequence equals accepted input sequence extended via reference model.

Source files
------------

// File: rtl/ext_pkg.sv
// ext_pkg: shared immediate-extension mode encodings.
// Used by ext_core and by any decoder driving ext_op.
package ext_pkg;

    localparam int EXT_OP_W = 3;

    localparam logic [EXT_OP_W-1:0] EXT_SIGN   = 3'd0;
    localparam logic [EXT_OP_W-1:0] EXT_ZERO   = 3'd1;
    localparam logic [EXT_OP_W-1:0] EXT_UPPER  = 3'd2;
    localparam logic [EXT_OP_W-1:0] EXT_BRANCH = 3'd3;
    localparam logic [EXT_OP_W-1:0] EXT_ZSHL2  = 3'd4;

endpackage

// File: rtl/ext_core.sv
// ext_core: combinational immediate extender.
// Ports: imm (IMM_W), ext_op (mode) -> result (DATA_W); ops 5..7 give 0.
module ext_core
    import ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic [IMM_W-1:0]    imm,
    input  logic [EXT_OP_W-1:0] ext_op,
    output logic [DATA_W-1:0]   result
);

    localparam int PAD = DATA_W - IMM_W;

    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] zext;

    assign sext = {{PAD{imm[IMM_W-1]}}, imm};
    assign zext = {{PAD{1'b0}}, imm};

    always_comb begin
        result = '0;
        case (ext_op)
            EXT_SIGN:   result = sext;
            EXT_ZERO:   result = zext;
            EXT_UPPER:  result = {imm, {PAD{1'b0}}};
            EXT_BRANCH: result = sext << 2;
            EXT_ZSHL2:  result = zext << 2;
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: registered immediate-extension stage with a 2-entry skid buffer.
// Ports: clk, reset (async, active-low), flush; in_valid/in_ready/imm/ext_op/in_tag;
//        out_valid/out_ready/out_data/out_tag; occupancy (entries held).
module ext_pipe
    import ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IMM_W-1:0]    imm,
    input  logic [EXT_OP_W-1:0] ext_op,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic [1:0]          occupancy
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } ent_t;

    ent_t              m_q;
    ent_t              s_q;
    ent_t              in_ent;
    logic              m_v;
    logic              s_v;
    logic [DATA_W-1:0] ext_res;
    logic              in_xfer;
    logic              drain;

    ext_core #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) u_core (
        .imm    (imm),
        .ext_op (ext_op),
        .result (ext_res)
    );

    // Ready depends only on flops (and reset), never on out_ready.
    assign in_ready = reset & ~s_v;
    assign in_xfer  = in_valid & in_ready;
    // M can take a new entry when empty or handing its entry off.
    assign drain    = ~m_v | out_ready;
    assign in_ent   = '{data: ext_res, tag: in_tag};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_v <= 1'b0;
            s_v <= 1'b0;
            m_q <= '0;
            s_q <= '0;
        end else if (flush) begin
            m_v <= 1'b0;
            s_v <= 1'b0;
        end else if (drain) begin
            if (s_v) begin
                m_q <= s_q;
                m_v <= 1'b1;
                s_v <= in_xfer;
                if (in_xfer) s_q <= in_ent;
            end else begin
                m_v <= in_xfer;
                if (in_xfer) m_q <= in_ent;
            end
        end else if (in_xfer) begin
            s_v <= 1'b1;
            s_q <= in_ent;
        end
    end

    assign out_valid = m_v;
    assign out_data  = m_q.data;
    assign out_tag   = m_q.tag;
    assign occupancy = {1'b0, m_v} + {1'b0, s_v};

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: randomized self-checking bench for ext_pipe.
// Reference: 2-deep FIFO queue plus arithmetic extension model.
module tb_ext_pipe;

    localparam int IMM_W  = 16;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 32;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [IMM_W-1:0]  imm;
    logic [2:0]        ext_op;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic [1:0]        occupancy;

    int n_cmp;
    int n_err;

    logic [63:0] q[$];

    ext_pipe #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm       (imm),
        .ext_op    (ext_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_ext(input logic [15:0] v, input logic [2:0] op);
        longint u;
        longint s;
        longint r;
        u = longint'(v);
        s = (u >= 32768) ? u - 65536 : u;
        case (op)
            3'd0:    r = s;
            3'd1:    r = u;
            3'd2:    r = u * 65536;
            3'd3:    r = s * 4;
            3'd4:    r = u * 4;
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    // Advance one clock; update the FIFO model with what the edge does.
    task automatic cycle(output bit acc);
        bit inx;
        bit outx;
        logic [63:0] ent;
        inx = in_valid && (q.size() < 2);
        outx = out_ready && (q.size() > 0);
        ent = {ref_ext(imm, ext_op), in_tag};
        @(posedge clk);
        acc = inx && reset && !flush;
        if (!reset || flush) begin
            q.delete();
        end else begin
            if (outx) void'(q.pop_front());
            if (inx) q.push_back(ent);
        end
        #1;
    endtask

    task automatic drive_rand();
        imm = IMM_W'($urandom);
        ext_op = 3'($urandom_range(0, 7));
        in_tag = $urandom;
    endtask

    task automatic test_reset();
        bit acc;
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        imm = '0;
        ext_op = '0;
        in_tag = '0;
        #1 reset = 1'b0;
        #2;
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_err++;
            $display("FAIL reset_state got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
        end
        n_cmp++;
        if (out_data !== 32'h0 || out_tag !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data got %h/%h want 0/0", out_data, out_tag);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        cycle(acc);
        cycle(acc);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || occupancy !== 2'd0) begin
            n_err++;
            $display("FAIL release_ready got rdy=%b occ=%0d want 1/0", in_ready, occupancy);
        end
    endtask

    task automatic test_modes();
        logic [15:0] t_imm[6];
        logic [2:0]  t_op[6];
        logic [31:0] t_exp[6];
        bit acc;
        t_imm = '{16'h8000, 16'h8000, 16'h1234, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        t_op  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        t_exp = '{32'hFFFF8000, 32'h00008000, 32'h12340000,
                  32'hFFFFFFFC, 32'h0003FFFC, 32'h00000000};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            imm = t_imm[i];
            ext_op = t_op[i];
            in_tag = 32'h100 + i;
            cycle(acc);
            in_valid = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== t_exp[i] || out_tag !== 32'h100 + i) begin
                n_err++;
                $display("FAIL mode_%0d got v=%b %h tag %h want 1 %h tag %h",
                         t_op[i], out_valid, out_data, out_tag, t_exp[i], 32'h100 + i);
            end
            cycle(acc);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_tag[3];
        int k;
        int nacc;
        bit acc;
        exp_tag = '{32'd1, 32'd2, 32'd3};
        out_ready = 1'b0;
        in_valid = 1'b1;
        imm = 16'h0042;
        ext_op = 3'd1;
        nacc = 0;
        for (int t = 1; t <= 3; t++) begin
            in_tag = t;
            cycle(acc);
            if (acc) nacc++;
        end
        n_cmp++;
        if (in_ready !== 1'b0 || occupancy !== 2'd2 || nacc != 2) begin
            n_err++;
            $display("FAIL bp_full got rdy=%b occ=%0d acc=%0d want 0/2/2",
                     in_ready, occupancy, nacc);
        end
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (k > 2 || out_tag !== exp_tag[k > 2 ? 2 : k]) begin
                    n_err++;
                    $display("FAIL bp_order idx %0d got tag %0d want %0d",
                             k, out_tag, exp_tag[k > 2 ? 2 : k]);
                end
                k++;
            end
            cycle(acc);
            if (acc) begin
                nacc++;
                in_valid = 1'b0;
            end
        end
        n_cmp++;
        if (k != 3 || nacc != 3) begin
            n_err++;
            $display("FAIL bp_count got out=%0d acc=%0d want 3/3", k, nacc);
        end
    endtask

    task automatic test_stream();
        bit acc;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive_rand();
            cycle(acc);
            n_cmp++;
            if (!acc || out_valid !== 1'b1 || occupancy !== 2'd1) begin
                n_err++;
                $display("FAIL stream_flow i=%0d acc=%0d v=%b occ=%0d want 1/1/1",
                         i, acc, out_valid, occupancy);
            end
            n_cmp++;
            if (q.size() == 0 || {out_data, out_tag} !== q[0]) begin
                n_err++;
                $display("FAIL stream_data i=%0d got %h/%h want %h",
                         i, out_data, out_tag, q.size() ? q[0] : 64'h0);
            end
        end
        in_valid = 1'b0;
        cycle(acc);
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_err++;
            $display("FAIL stream_drain got v=%b occ=%0d want 0/0", out_valid, occupancy);
        end
    endtask

    task automatic test_flush();
        bit acc;
        out_ready = 1'b0;
        in_valid = 1'b1;
        drive_rand();
        cycle(acc);
        drive_rand();
        cycle(acc);
        n_cmp++;
        if (occupancy !== 2'd2) begin
            n_err++;
            $display("FAIL flush_pre_occ got %0d want 2", occupancy);
        end
        out_ready = 1'b1;
        flush = 1'b1;
        in_tag = 32'hDEAD_BEEF;
        cycle(acc);
        flush = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_state got v=%b occ=%0d rdy=%b want 0/0/1",
                     out_valid, occupancy, in_ready);
        end
        for (int c = 0; c < 4; c++) begin
            cycle(acc);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL flush_ghost got v=%b tag %h want v=0", out_valid, out_tag);
            end
        end
    endtask

    task automatic test_async_reset();
        bit acc;
        logic [31:0] e;
        out_ready = 1'b0;
        in_valid = 1'b1;
        drive_rand();
        cycle(acc);
        drive_rand();
        cycle(acc);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL areset_now got v=%b occ=%0d rdy=%b want 0/0/0",
                     out_valid, occupancy, in_ready);
        end
        n_cmp++;
        if (out_data !== 32'h0 || out_tag !== 32'h0) begin
            n_err++;
            $display("FAIL areset_data got %h/%h want 0/0", out_data, out_tag);
        end
        cycle(acc);
        reset = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        imm = 16'h8001;
        ext_op = 3'd3;
        in_tag = 32'h0000_0A5A;
        e = 32'hFFFE0004;
        cycle(acc);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== e || out_tag !== 32'h0A5A) begin
            n_err++;
            $display("FAIL areset_after got v=%b %h/%h want 1 %h/00000a5a",
                     out_valid, out_data, out_tag, e);
        end
        cycle(acc);
    endtask

    task automatic test_random();
        bit acc;
        int nacc;
        int nout;
        nacc = 0;
        nout = 0;
        in_valid = 1'b0;
        for (int c = 0; c < 20000 && nout < 1000; c++) begin
            if (!in_valid && nacc < 1000 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                drive_rand();
            end
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid === 1'b1 && out_ready) nout++;
            cycle(acc);
            if (acc) begin
                nacc++;
                in_valid = 1'b0;
            end
            n_cmp++;
            if (occupancy !== 2'(q.size()) || in_ready !== (q.size() < 2)) begin
                n_err++;
                $display("FAIL rand_occ c=%0d got occ=%0d rdy=%b want %0d",
                         c, occupancy, in_ready, q.size());
            end
            n_cmp++;
            if (out_valid !== (q.size() > 0) ||
                (q.size() > 0 && {out_data, out_tag} !== q[0])) begin
                n_err++;
                $display("FAIL rand_out c=%0d got v=%b %h/%h want %h",
                         c, out_valid, out_data, out_tag, q.size() ? q[0] : 64'h0);
            end
        end
        n_cmp++;
        if (nacc != 1000 || nout != 1000) begin
            n_err++;
            $display("FAIL rand_count got acc=%0d out=%0d want 1000/1000", nacc, nout);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_modes();
        test_backpressure();
        test_stream();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
